// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the comm_uart receive/transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam logic [15:0] MIN_BAUD_DIV = 16'd4;

    // Even parity bit is the XOR of the data; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable bit-period down-counter, strobes expire for one cycle.
module uart_bit_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] count,
    output logic        expire
);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= count;
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    // A load of N strobes in the N-th cycle after the load edge.
    assign expire = (cnt == 16'd1);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with parity, break handling and
// a valid/ready holding register; rx_busy feeds the link watchdog.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [15:0]          baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(DATA_BITS + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    rx_state_t              state, state_next;
    logic [15:0]            div_q, div_eff, tmr_val;
    logic                   par_en_q, par_odd_q, par_bad;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   tmr_load, expire;
    logic                   start_det, shift, par_smp;
    logic                   stop_ok, stop_bad, load;

    assign rxs     = sync[SYNC_STAGES-1];
    assign div_eff = (baud_div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : baud_div;
    assign load    = stop_ok && !par_bad && (!dout_valid || dout_ready);

    uart_bit_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .count  (tmr_val),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '1;
            state <= ST_IDLE;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rxd};
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = div_q;
        start_det  = 1'b0;
        shift      = 1'b0;
        par_smp    = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_next = ST_START;
                        tmr_load   = 1'b1;
                        tmr_val    = div_eff >> 1;
                        start_det  = 1'b1;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        state_next = rxs ? ST_IDLE : ST_DATA;
                        tmr_load   = !rxs;
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shift    = 1'b1;
                        tmr_load = 1'b1;
                        if (bit_cnt == CW'(DATA_BITS - 1)) begin
                            state_next = par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (expire) begin
                        par_smp    = 1'b1;
                        tmr_load   = 1'b1;
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (expire) begin
                        stop_ok    = rxs;
                        stop_bad   = !rxs;
                        state_next = rxs ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rxs) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= MIN_BAUD_DIV;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_bad    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start_det) begin
                div_q     <= div_eff;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                par_bad   <= 1'b0;
                bit_cnt   <= '0;
            end
            if (shift) begin
                shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_smp) begin
                par_bad <= (rxs != parity_bit(shreg, par_odd_q));
            end
            // A new load wins over an accept in the same cycle.
            if (load) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            rx_busy    <= (state_next != ST_IDLE);
            frame_err  <= stop_bad;
            parity_err <= stop_ok && par_bad;
            overrun    <= stop_ok && !par_bad && dout_valid && !dout_ready;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: random and directed frames checked every cycle against a
// frame-level timing model of the receiver.
module tb_uart_rx_core;

    localparam int K_CHAR = 0;
    localparam int K_PAR  = 1;
    localparam int K_FRM  = 2;
    localparam int BIG    = 32'h3fffffff;

    logic        clk = 1'b0;
    logic        rst, en, rxd, parity_en, parity_odd, dout_ready;
    logic [15:0] baud_div;
    logic [7:0]  dout;
    logic        dout_valid, rx_busy, frame_err, parity_err, overrun;

    always #5 clk = ~clk;

    uart_rx_core dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rxd        (rxd),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int perr_seen = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;
    bit rand_ready = 1'b0;

    // Model: expected output events and busy windows, by cycle number.
    int         ev_cyc[$];
    int         ev_kind[$];
    logic [7:0] ev_dat[$];
    int         win_lo[$];
    int         win_hi[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_dout  = 8'h00;
    logic       m_busy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic       m_take;
    int         m_kind;
    logic [7:0] m_dat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    always @(posedge clk) begin
        cyc++;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_dout  = 8'h00;
            ev_cyc.delete();
            ev_kind.delete();
            ev_dat.delete();
            win_lo.delete();
            win_hi.delete();
        end else begin
            m_take = m_valid && dout_ready;
            if (!en) begin
                ev_cyc.delete();
                ev_kind.delete();
                ev_dat.delete();
                foreach (win_hi[i]) if (win_hi[i] > cyc - 1) win_hi[i] = cyc - 1;
            end
            if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
                void'(ev_cyc.pop_front());
                m_kind = ev_kind.pop_front();
                m_dat  = ev_dat.pop_front();
                if (m_kind == K_CHAR) begin
                    if (!m_valid || dout_ready) begin
                        m_valid = 1'b1;
                        m_dout  = m_dat;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    if (m_kind == K_PAR) m_perr = 1'b1;
                    else m_ferr = 1'b1;
                    if (m_take) m_valid = 1'b0;
                end
            end else if (m_take) begin
                m_valid = 1'b0;
            end
        end
        m_busy = 1'b0;
        foreach (win_lo[i]) if (cyc >= win_lo[i] && cyc <= win_hi[i]) m_busy = 1'b1;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("rx_busy", 32'(rx_busy), 32'(m_busy));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (parity_err === 1'b1) perr_seen++;
            if (frame_err === 1'b1) ferr_seen++;
            if (overrun === 1'b1) ovr_seen++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    end

    // Bit i of a frame launched at t0 is sampled at t0+1+half+i*B (two-flop
    // sync, half-bit start resample), outputs register one cycle later.
    task automatic send(input logic [7:0] d, input logic [15:0] bdiv,
                        input bit pen, input bit podd, input bit pflip,
                        input bit stopv, input int hold,
                        input int abort_at, input bit abort_en);
        int b, h, t0, s, nb, n;
        logic [10:0] bits;
        b  = (bdiv < 16'd4) ? 4 : int'(bdiv);
        h  = b / 2;
        t0 = cyc + 1;
        nb = pen ? 11 : 10;
        s  = t0 + 1 + h + b * (nb - 1);
        baud_div   = bdiv;
        parity_en  = pen;
        parity_odd = podd;
        win_lo.push_back(t0 + 2);
        win_hi.push_back(stopv ? s : BIG);
        ev_cyc.push_back(s + 1);
        ev_kind.push_back(!stopv ? K_FRM : (pen && pflip) ? K_PAR : K_CHAR);
        ev_dat.push_back(d);
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pen) bits[9] = (^d) ^ podd ^ pflip;
        bits[nb-1] = stopv;
        n = 0;
        for (int j = 0; j < nb; j++) begin
            rxd = bits[j];
            for (int k = 0; k < ((j == nb - 1 && !stopv) ? hold : b); k++) begin
                step();
                n++;
                if (n == b) begin
                    baud_div   = 16'($urandom);
                    parity_en  = 1'($urandom);
                    parity_odd = 1'($urandom);
                end
                if (abort_at > 0 && n == abort_at) begin
                    rxd = 1'b1;
                    if (!abort_en) begin
                        rst = 1'b1;
                        step();
                        rst = 1'b0;
                        @(negedge clk);
                        chk("rst_busy", 32'(rx_busy), 0);
                        chk("rst_valid", 32'(dout_valid), 0);
                        chk("rst_dout", 32'(dout), 0);
                    end else begin
                        en = 1'b0;
                        step();
                        @(negedge clk);
                        chk("en_busy", 32'(rx_busy), 0);
                    end
                    repeat (3) step();
                    en = 1'b1;
                    return;
                end
            end
        end
        if (!stopv) begin
            rxd = 1'b1;
            win_hi[win_hi.size() - 1] = cyc + 2;
            step();
        end
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        repeat (2) step();
        dout_ready = 1'b0;
    endtask

    int t0, base, bsel, bq;
    logic [15:0] rb;
    bit rp, ro, rf, rs;

    initial begin
        rst = 1'b1; en = 1'b1; rxd = 1'b1;
        baud_div = 16'd16; parity_en = 1'b0; parity_odd = 1'b0;
        dout_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_dout", 32'(dout), 0);
        chk("reset_valid", 32'(dout_valid), 0);
        chk("reset_busy", 32'(rx_busy), 0);
        step();
        rst = 1'b0;
        repeat (4) step();

        // 0xA5 at 16 clocks/bit, no parity
        t0 = cyc + 1;
        base = perr_seen + ferr_seen + ovr_seen;
        fork
            send(8'hA5, 16'd16, 0, 0, 0, 1, 0, 0, 0);
            begin
                wait_cycle(t0 + 1);
                chk("t1_busy_pre", 32'(rx_busy), 0);
                wait_cycle(t0 + 2);
                chk("t1_busy_on", 32'(rx_busy), 1);
                wait_cycle(t0 + 153);
                chk("t1_valid_pre", 32'(dout_valid), 0);
                chk("t1_busy_stop", 32'(rx_busy), 1);
                wait_cycle(t0 + 154);
                chk("t1_valid", 32'(dout_valid), 1);
                chk("t1_dout", 32'(dout), 32'h00A5);
                chk("t1_busy_off", 32'(rx_busy), 0);
            end
        join
        chk("t1_errs", 32'(perr_seen + ferr_seen + ovr_seen - base), 0);
        drain();

        // even parity, wrong then right parity bit
        base = perr_seen;
        send(8'h3C, 16'd16, 1, 0, 1, 1, 0, 0, 0);
        chk("t2_perr", 32'(perr_seen - base), 1);
        chk("t2_novalid", 32'(dout_valid), 0);
        send(8'h3C, 16'd16, 1, 0, 0, 1, 0, 0, 0);
        chk("t2_valid", 32'(dout_valid), 1);
        chk("t2_dout", 32'(dout), 32'h003C);
        drain();

        // false start: 5 clocks low
        t0 = cyc + 1;
        baud_div = 16'd16;
        parity_en = 1'b0;
        win_lo.push_back(t0 + 2);
        win_hi.push_back(t0 + 9);
        fork
            begin
                rxd = 1'b0;
                repeat (5) step();
                rxd = 1'b1;
                repeat (20) step();
            end
            begin
                wait_cycle(t0 + 2);
                chk("t3_busy_on", 32'(rx_busy), 1);
                wait_cycle(t0 + 11);
                chk("t3_busy_off", 32'(rx_busy), 0);
            end
        join

        // break: stop bit held low 400 clocks
        t0 = cyc + 1;
        base = ferr_seen;
        fork
            send(8'h55, 16'd16, 0, 0, 0, 0, 400, 0, 0);
            begin
                wait_cycle(t0 + 300);
                chk("t4_busy_break", 32'(rx_busy), 1);
            end
        join
        repeat (2) step();
        @(negedge clk);
        chk("t4_busy_idle", 32'(rx_busy), 0);
        chk("t4_ferr", 32'(ferr_seen - base), 1);
        step();
        send(8'h12, 16'd16, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_dout", 32'(dout), 32'h0012);
        drain();

        // overrun with consumer stalled
        base = ovr_seen;
        send(8'h11, 16'd16, 0, 0, 0, 1, 0, 0, 0);
        send(8'h22, 16'd16, 0, 0, 0, 1, 0, 0, 0);
        chk("t5_ovr", 32'(ovr_seen - base), 1);
        chk("t5_dout", 32'(dout), 32'h0011);
        dout_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t5_valid_drop", 32'(dout_valid), 0);
        chk("t5_dout_keep", 32'(dout), 32'h0011);
        step();
        dout_ready = 1'b0;

        // mid-frame reset, then mid-frame enable drop
        send(8'h77, 16'd16, 0, 0, 0, 1, 0, 0, 0);
        send(8'h99, 16'd16, 0, 0, 0, 1, 0, 72, 0);
        send(8'h5A, 16'd16, 0, 0, 0, 1, 0, 0, 0);
        chk("t6_dout", 32'(dout), 32'h005A);
        drain();
        send(8'h66, 16'd5, 1, 1, 0, 1, 0, 22, 1);
        repeat (30) step();
        chk("t6_no_char", 32'(dout_valid), 0);

        // randomized frames, including divisors below the minimum
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rb = 16'($urandom_range(0, 20));
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rf = rp && ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 5) != 0);
            bsel = (rb < 16'd4) ? 4 : int'(rb);
            bq = bsel + int'($urandom_range(0, 2 * bsel));
            send(8'($urandom), rb, rp, ro, rf, rs, bq, 0, 0);
            repeat ($urandom_range(0, bsel)) step();
        end
        rand_ready = 1'b0;
        step();
        dout_ready = 1'b1;
        repeat (60) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL timeout cyc=%0d got=running want=done", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
